pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameters (name, default, meaning): PC_WIDTH, 8, program counter width.
REQ-002 SHALL have parameter DATA_WIDTH, 8, width of ALU compare result.
REQ-003 SHALL have parameter STACK_DEPTH, 4, return-address stack entries (power of two, >=2).
REQ-004 SHALL have ports (name, direction, width, meaning): clk, in, 1, sole clock; all state updates on rising edge.
REQ-005 SHALL have reset, in, 1, asynchronous active-high reset.
REQ-006 SHALL have Start, in, 1, load StartPC and begin execution.
REQ-007 SHALL have StartPC, in, PC_WIDTH, initial PC.
REQ-008 SHALL have Update, in, 1, commit one instruction this cycle.
REQ-009 SHALL have NZPWrite, in, 1, latch NZP from AluResult on committed instruction.
REQ-010 SHALL have AluResult, in, DATA_WIDTH, two's-complement compare result.
REQ-011 SHALL have BranchEn, in, 1, conditional branch instruction.
REQ-012 SHALL have BranchMask, in, 3, {N,Z,P} condition mask.
REQ-013 SHALL have Immediate, in, PC_WIDTH, branch/call target.
REQ-014 SHALL have CallEn and RetEn, in, 1 each, push / pop return address.
REQ-015 SHALL have HaltEn, in, 1, halt instruction.
REQ-016 SHALL have CurrentPC, out, PC_WIDTH, registered PC.
REQ-017 SHALL have NextPC, out, PC_WIDTH, combinational PC the current Update would load.
REQ-018 SHALL have NZP, out, 3, registered flags {N,Z,P}.
REQ-019 SHALL have Running, Done, Fault, out, 1 each, state indicators.
REQ-020 SHALL have StackCount, out, $clog2(STACK_DEPTH)+1, occupied stack entries.

Function
REQ-021 SHALL implement states IDLE, RUN, DONE, FAULT; Running=1 only in RUN, Done=1 only in DONE, Fault=1 only in FAULT.
REQ-022 SHALL move IDLE->RUN on Start, loading CurrentPC=StartPC, NZP=000, StackCount=0, same edge.
REQ-023 SHALL accept Start in any state (restart), with identical effect to REQ-022.
REQ-024 SHALL ignore Update outside RUN; in RUN without Update, all state holds.
REQ-025 SHALL compute NextPC priority: HaltEn -> CurrentPC; RetEn -> top of stack; CallEn -> Immediate; BranchEn and |(BranchMask & NZP) -> Immediate; else CurrentPC+1 modulo 2^PC_WIDTH.
REQ-026 SHALL wrap PC+1 from all-ones to zero without fault.
REQ-027 SHALL evaluate branch condition against NZP registered before this edge, not the value written by the same Update.
REQ-028 SHALL, on Update with NZPWrite, set NZP to exactly one hot: 100 if AluResult negative, 010 if zero, 001 if positive.
REQ-029 SHALL, on Update with CallEn, push CurrentPC+1 (wrapped) and increment StackCount.
REQ-030 SHALL, on Update with RetEn, pop top and decrement StackCount.
REQ-031 SHALL, on Update with HaltEn, enter DONE; CurrentPC, NZP, stack hold.
REQ-032 SHALL enter FAULT, holding CurrentPC and stack, on CallEn with StackCount==STACK_DEPTH (overflow) or RetEn with StackCount==0 (underflow).
REQ-033 SHALL treat simultaneous CallEn and RetEn on one Update as RetEn only; lower-priority enables are ignored when a higher one is set, except NZPWrite, which applies independently.
REQ-034 SHALL leave DONE and FAULT only via Start or reset.
REQ-035 SHALL have one-cycle latency: CurrentPC equals prior NextPC on the edge after Update.

Reset
REQ-036 SHALL, on reset assertion, asynchronously force state IDLE, CurrentPC=0, NZP=000, StackCount=0, Running=Done=Fault=0.
REQ-037 SHALL abandon any in-progress program when reset asserts mid-RUN; stack contents need not be cleared but are unreachable.
REQ-038 SHALL require Start after reset deassertion to resume execution.

Verification
REQ-039 SHALL cover: Start with StartPC=0x10, then 3 plain Updates -> CurrentPC 0x11,0x12,0x13; Running=1.
REQ-040 SHALL cover: NZPWrite with AluResult=0x00, next Update BranchEn, mask 010, Immediate 0x40 -> NZP=010, CurrentPC=0x40; mask 100 instead -> PC+1.
REQ-041 SHALL cover: CurrentPC=0xFF, Update -> CurrentPC=0x00, Fault=0.
REQ-042 SHALL cover: CallEn at PC 0x05 (target 0x20), then RetEn -> PC 0x20 then 0x06; StackCount 1 then 0; 5th nested Call with STACK_DEPTH=4 -> Fault=1, PC held.
REQ-043 SHALL cover: RetEn with empty stack -> Fault=1; then Start StartPC=0x00 -> RUN, Fault=0.
REQ-044 SHALL cover: HaltEn at PC 0x09 -> Done=1, PC stays 0x09 under further Updates; reset mid-RUN -> CurrentPC=0, IDLE immediately without clock edge.

Source files
------------

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program counter sequencer with flags, branch, call/return stack and halt/fault states
module pc_sequencer #(
  parameter int PC_WIDTH    = 8,
  parameter int DATA_WIDTH  = 8,
  parameter int STACK_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           Start,
  input  logic [PC_WIDTH-1:0]            StartPC,
  input  logic                           Update,
  input  logic                           NZPWrite,
  input  logic [DATA_WIDTH-1:0]          AluResult,
  input  logic                           BranchEn,
  input  logic [2:0]                     BranchMask,
  input  logic [PC_WIDTH-1:0]            Immediate,
  input  logic                           CallEn,
  input  logic                           RetEn,
  input  logic                           HaltEn,
  output logic [PC_WIDTH-1:0]            CurrentPC,
  output logic [PC_WIDTH-1:0]            NextPC,
  output logic [2:0]                     NZP,
  output logic                           Running,
  output logic                           Done,
  output logic                           Fault,
  output logic [$clog2(STACK_DEPTH):0]   StackCount
);

  localparam int AW = $clog2(STACK_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(STACK_DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;
  localparam logic [1:0] S_FAULT = 2'd3;

  logic [1:0]          state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [2:0]          nzp_q, nzp_d;
  logic [CW-1:0]       sp_q, sp_d;
  logic [PC_WIDTH-1:0] stack_q [STACK_DEPTH];

  logic [PC_WIDTH-1:0] pc_inc;
  logic [PC_WIDTH-1:0] stack_top;
  logic [CW-1:0]       sp_m1;
  logic [2:0]          alu_flags;
  logic                push;
  logic                commit;

  assign pc_inc    = pc_q + PC_WIDTH'(1);
  assign sp_m1     = sp_q - CW'(1);
  assign stack_top = stack_q[sp_m1[AW-1:0]];
  assign alu_flags = AluResult[DATA_WIDTH-1] ? 3'b100 :
                     (AluResult == '0)       ? 3'b010 : 3'b001;
  assign commit    = (state_q == S_RUN) && Update;

  // Branch tests the flags held before this edge, never the ones being written.
  always_comb begin
    NextPC = pc_inc;
    if (HaltEn)                                 NextPC = pc_q;
    else if (RetEn)                             NextPC = stack_top;
    else if (CallEn)                            NextPC = Immediate;
    else if (BranchEn && |(BranchMask & nzp_q)) NextPC = Immediate;
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    nzp_d   = nzp_q;
    sp_d    = sp_q;
    push    = 1'b0;
    if (Start) begin
      state_d = S_RUN;
      pc_d    = StartPC;
      nzp_d   = 3'b000;
      sp_d    = '0;
    end else if (commit) begin
      if (!HaltEn && NZPWrite) nzp_d = alu_flags;
      if (HaltEn) begin
        state_d = S_DONE;
      end else if (RetEn) begin
        if (sp_q == '0) begin
          state_d = S_FAULT;
        end else begin
          pc_d = NextPC;
          sp_d = sp_m1;
        end
      end else if (CallEn) begin
        if (sp_q == FULL) begin
          state_d = S_FAULT;
        end else begin
          pc_d = NextPC;
          sp_d = sp_q + CW'(1);
          push = 1'b1;
        end
      end else begin
        pc_d = NextPC;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      nzp_q   <= 3'b000;
      sp_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      nzp_q   <= nzp_d;
      sp_q    <= sp_d;
    end
  end

  // Stack contents are unreachable once the count is cleared, so they skip reset.
  always_ff @(posedge clk) begin
    if (push) stack_q[sp_q[AW-1:0]] <= pc_inc;
  end

  assign CurrentPC  = pc_q;
  assign NZP        = nzp_q;
  assign StackCount = sp_q;
  assign Running    = (state_q == S_RUN);
  assign Done       = (state_q == S_DONE);
  assign Fault      = (state_q == S_FAULT);

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed and randomized checks of pc_sequencer against a queue-based model
module tb_pc_sequencer;
  localparam int PW = 8;
  localparam int DW = 8;
  localparam int SD = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          Start, Update, NZPWrite, BranchEn, CallEn, RetEn, HaltEn;
  logic [PW-1:0] StartPC, Immediate;
  logic [DW-1:0] AluResult;
  logic [2:0]    BranchMask;
  logic [PW-1:0] CurrentPC, NextPC;
  logic [2:0]    NZP;
  logic          Running, Done, Fault;
  logic [2:0]    StackCount;

  int checks = 0;
  int errors = 0;

  typedef enum int {M_IDLE, M_RUN, M_DONE, M_FAULT} mstate_t;
  mstate_t       m_st;
  logic [PW-1:0] m_pc;
  logic [2:0]    m_nzp;
  logic [PW-1:0] m_stk[$];

  always #5 clk = ~clk;

  pc_sequencer #(.PC_WIDTH(PW), .DATA_WIDTH(DW), .STACK_DEPTH(SD)) dut (
    .clk(clk), .reset(reset), .Start(Start), .StartPC(StartPC), .Update(Update),
    .NZPWrite(NZPWrite), .AluResult(AluResult), .BranchEn(BranchEn), .BranchMask(BranchMask),
    .Immediate(Immediate), .CallEn(CallEn), .RetEn(RetEn), .HaltEn(HaltEn),
    .CurrentPC(CurrentPC), .NextPC(NextPC), .NZP(NZP), .Running(Running), .Done(Done),
    .Fault(Fault), .StackCount(StackCount)
  );

  task automatic clear_in();
    Start = 0; StartPC = '0; Update = 0; NZPWrite = 0; AluResult = '0; BranchEn = 0;
    BranchMask = '0; Immediate = '0; CallEn = 0; RetEn = 0; HaltEn = 0;
  endtask

  task automatic m_reset();
    m_st = M_IDLE; m_pc = '0; m_nzp = 3'b000; m_stk.delete();
  endtask

  function automatic logic [PW-1:0] m_next();
    if (HaltEn) return m_pc;
    if (RetEn) return m_stk[$];
    if (CallEn) return Immediate;
    if (BranchEn && (BranchMask & m_nzp) != 3'b000) return Immediate;
    return PW'(m_pc + 1);
  endfunction

  task automatic m_edge();
    logic [PW-1:0] np;
    if (reset) return;
    np = (RetEn && !HaltEn && m_stk.size() == 0) ? m_pc : m_next();
    if (Start) begin
      m_st = M_RUN; m_pc = StartPC; m_nzp = 3'b000; m_stk.delete();
    end else if (m_st == M_RUN && Update) begin
      if (!HaltEn && NZPWrite)
        m_nzp = ($signed(AluResult) < 0) ? 3'b100 : (AluResult == 0) ? 3'b010 : 3'b001;
      if (HaltEn) m_st = M_DONE;
      else if (RetEn) begin
        if (m_stk.size() == 0) m_st = M_FAULT;
        else m_pc = m_stk.pop_back();
      end else if (CallEn) begin
        if (m_stk.size() == SD) m_st = M_FAULT;
        else begin m_stk.push_back(PW'(m_pc + 1)); m_pc = Immediate; end
      end else m_pc = np;
    end
  endtask

  task automatic step();
    m_edge();
    @(posedge clk);
    #1;
    clear_in();
  endtask

  task automatic test_reset();
    clear_in();
    reset = 1; m_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (CurrentPC !== 8'h00) begin errors++; $display("FAIL reset_pc got %h exp 00", CurrentPC); end
    checks++; if ({Running, Done, Fault} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b exp 000", {Running, Done, Fault}); end
    checks++; if ({NZP, StackCount} !== 6'b0) begin errors++; $display("FAIL reset_nzp_cnt got %b %0d exp 000 0", NZP, StackCount); end
    reset = 0;
    Update = 1; step();
    checks++; if (CurrentPC !== 8'h00 || Running !== 1'b0) begin errors++; $display("FAIL idle_update got pc %h run %b exp 00 0", CurrentPC, Running); end
  endtask

  task automatic test_sequential();
    logic [PW-1:0] exp_pc;
    Start = 1; StartPC = 8'h10; step();
    checks++; if (CurrentPC !== 8'h10 || Running !== 1'b1) begin errors++; $display("FAIL start_pc got %h run %b exp 10 1", CurrentPC, Running); end
    for (int i = 1; i <= 3; i++) begin
      exp_pc = PW'(8'h10 + i);
      Update = 1; #1;
      checks++; if (NextPC !== exp_pc) begin errors++; $display("FAIL seq_nextpc got %h exp %h", NextPC, exp_pc); end
      step();
      checks++; if (CurrentPC !== exp_pc) begin errors++; $display("FAIL seq_pc got %h exp %h", CurrentPC, exp_pc); end
    end
    step();
    checks++; if (CurrentPC !== 8'h13 || Running !== 1'b1) begin errors++; $display("FAIL hold_no_update got %h %b exp 13 1", CurrentPC, Running); end
  endtask

  task automatic test_branch();
    Start = 1; StartPC = 8'h30; step();
    Update = 1; NZPWrite = 1; AluResult = 8'h00; step();
    checks++; if (NZP !== 3'b010 || CurrentPC !== 8'h31) begin errors++; $display("FAIL nzp_zero got %b %h exp 010 31", NZP, CurrentPC); end
    Update = 1; BranchEn = 1; BranchMask = 3'b010; Immediate = 8'h40; step();
    checks++; if (CurrentPC !== 8'h40) begin errors++; $display("FAIL branch_taken got %h exp 40", CurrentPC); end
    Update = 1; BranchEn = 1; BranchMask = 3'b100; Immediate = 8'h60; step();
    checks++; if (CurrentPC !== 8'h41) begin errors++; $display("FAIL branch_not_taken got %h exp 41", CurrentPC); end
    Update = 1; NZPWrite = 1; AluResult = 8'h80; BranchEn = 1; BranchMask = 3'b100; Immediate = 8'h60; step();
    checks++; if (CurrentPC !== 8'h42 || NZP !== 3'b100) begin errors++; $display("FAIL branch_old_nzp got %h %b exp 42 100", CurrentPC, NZP); end
    Update = 1; NZPWrite = 1; AluResult = 8'h7F; step();
    checks++; if (NZP !== 3'b001) begin errors++; $display("FAIL nzp_pos got %b exp 001", NZP); end
  endtask

  task automatic test_wrap();
    Start = 1; StartPC = 8'hFF; step();
    Update = 1; step();
    checks++; if (CurrentPC !== 8'h00 || Fault !== 1'b0 || Running !== 1'b1) begin errors++; $display("FAIL wrap got %h fault %b exp 00 0", CurrentPC, Fault); end
  endtask

  task automatic test_call_ret();
    Start = 1; StartPC = 8'h05; step();
    Update = 1; CallEn = 1; Immediate = 8'h20; step();
    checks++; if (CurrentPC !== 8'h20 || StackCount !== 3'd1) begin errors++; $display("FAIL call got %h %0d exp 20 1", CurrentPC, StackCount); end
    Update = 1; RetEn = 1; CallEn = 1; Immediate = 8'h77; step();
    checks++; if (CurrentPC !== 8'h06 || StackCount !== 3'd0) begin errors++; $display("FAIL ret got %h %0d exp 06 0", CurrentPC, StackCount); end
    for (int i = 0; i < SD; i++) begin
      Update = 1; CallEn = 1; Immediate = PW'(8'h30 + i); step();
    end
    checks++; if (CurrentPC !== 8'h33 || StackCount !== 3'd4) begin errors++; $display("FAIL nest4 got %h %0d exp 33 4", CurrentPC, StackCount); end
    Update = 1; CallEn = 1; Immediate = 8'h50; step();
    checks++; if (Fault !== 1'b1 || Running !== 1'b0 || CurrentPC !== 8'h33 || StackCount !== 3'd4) begin errors++; $display("FAIL overflow got f%b pc %h cnt %0d exp f1 33 4", Fault, CurrentPC, StackCount); end
    Update = 1; step();
    checks++; if (Fault !== 1'b1 || CurrentPC !== 8'h33) begin errors++; $display("FAIL fault_hold got f%b %h exp 1 33", Fault, CurrentPC); end
  endtask

  task automatic test_underflow();
    Start = 1; StartPC = 8'h00; step();
    Update = 1; RetEn = 1; step();
    checks++; if (Fault !== 1'b1 || CurrentPC !== 8'h00) begin errors++; $display("FAIL underflow got f%b %h exp 1 00", Fault, CurrentPC); end
    Start = 1; StartPC = 8'h00; step();
    checks++; if (Fault !== 1'b0 || Running !== 1'b1) begin errors++; $display("FAIL restart got f%b r%b exp 0 1", Fault, Running); end
  endtask

  task automatic test_halt_reset();
    Start = 1; StartPC = 8'h09; step();
    Update = 1; HaltEn = 1; #1;
    checks++; if (NextPC !== 8'h09) begin errors++; $display("FAIL halt_nextpc got %h exp 09", NextPC); end
    step();
    checks++; if (Done !== 1'b1 || Running !== 1'b0 || CurrentPC !== 8'h09) begin errors++; $display("FAIL halt got d%b %h exp 1 09", Done, CurrentPC); end
    repeat (2) begin Update = 1; step(); end
    checks++; if (Done !== 1'b1 || CurrentPC !== 8'h09) begin errors++; $display("FAIL done_hold got d%b %h exp 1 09", Done, CurrentPC); end
    Start = 1; StartPC = 8'h70; step();
    Update = 1; step();
    #2 reset = 1; m_reset();
    #1;
    checks++; if (CurrentPC !== 8'h00 || Running !== 1'b0 || StackCount !== 3'd0) begin errors++; $display("FAIL async_reset got %h r%b exp 00 0", CurrentPC, Running); end
    @(posedge clk); #1 reset = 0;
    Update = 1; step();
    checks++; if (CurrentPC !== 8'h00 || Running !== 1'b0) begin errors++; $display("FAIL need_start got %h r%b exp 00 0", CurrentPC, Running); end
  endtask

  task automatic test_random();
    int op;
    logic [2:0] exp_cnt;
    for (int n = 0; n < 600; n++) begin
      Start = ($urandom_range(0, 29) == 0);
      StartPC = PW'($urandom);
      Update = ($urandom_range(0, 3) != 0);
      op = $urandom_range(0, 19);
      HaltEn = (op == 0);
      CallEn = (op >= 1 && op <= 4);
      RetEn = (op >= 4 && op <= 7);
      BranchEn = (op >= 8 && op <= 12);
      NZPWrite = (op >= 8) && ($urandom_range(0, 1) == 1);
      AluResult = ($urandom_range(0, 3) == 0) ? '0 : DW'($urandom);
      BranchMask = 3'($urandom);
      Immediate = PW'($urandom);
      #1;
      if (!(RetEn && !HaltEn && m_stk.size() == 0)) begin
        checks++; if (NextPC !== m_next()) begin errors++; $display("FAIL rnd_nextpc n=%0d got %h exp %h", n, NextPC, m_next()); end
      end
      step();
      exp_cnt = 3'(m_stk.size());
      checks++; if (CurrentPC !== m_pc) begin errors++; $display("FAIL rnd_pc n=%0d got %h exp %h", n, CurrentPC, m_pc); end
      checks++; if (NZP !== m_nzp) begin errors++; $display("FAIL rnd_nzp n=%0d got %b exp %b", n, NZP, m_nzp); end
      checks++; if (StackCount !== exp_cnt) begin errors++; $display("FAIL rnd_cnt n=%0d got %0d exp %0d", n, StackCount, exp_cnt); end
      checks++;
      if ({Running, Done, Fault} !== {m_st == M_RUN, m_st == M_DONE, m_st == M_FAULT}) begin
        errors++; $display("FAIL rnd_state n=%0d got %b exp %b", n, {Running, Done, Fault}, {m_st == M_RUN, m_st == M_DONE, m_st == M_FAULT});
      end
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_branch();
    test_wrap();
    test_call_ret();
    test_underflow();
    test_halt_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
